// File: rtl/uart_tx_if.sv
// UART transmitter request/status bundle.
// The client raises tx_start with a byte on din; the transmitter reports
// the serial line, its busy flag and an end-of-frame strobe.
`timescale 1ns/1ps
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output din,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  din,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter timed by a shared 16x-baud tick.
// Frame: start bit, DBIT data bits LSB first, optional parity bit, then a
// stop phase of SB_TICK ticks. Every bit other than stop lasts 16 ticks.
// tx comes straight from a flop. Its next value is derived from the next
// state, so the line changes on the same edge as the state.
`timescale 1ns/1ps
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    s_tick,
    uart_tx_if.slave bus
);
    localparam int SW = $clog2(SB_TICK);
    localparam logic [SW-1:0] S_LAST_BIT  = SW'(15);
    localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    // Next-state logic. Counters move only on s_tick; the parity bit is
    // captured at accept so later din changes cannot disturb the frame.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    state_d           = ST_START;
                    s_d               = '0;
                    n_d               = '0;
                    b_d               = '0;
                    b_d[DBIT-1:0]     = bus.din[DBIT-1:0];
                    par_d             = (^bus.din[DBIT-1:0]) ^ (PARITY == 2);
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d = '0;
                        b_d = {1'b0, b_q[7:1]};
                        n_d = n_q + 1'b1;
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST_BIT) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST_STOP) begin
                        s_d     = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial line value for the state being entered, so tx is registered.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset that wins over any request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = (state_q != ST_IDLE);
    assign bus.tx_done_tick = done_q;
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 The block SHALL have parameter SB_TICK, default 16, number of s_tick periods in the stop phase (16, 24 or 32 for 1, 1.5 or 2 stop bits).
REQ-003 The block SHALL have parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-006 The block SHALL have port s_tick  input  1  one-clk pulse at 16x baud rate, from the shared baud generator.
REQ-007 The block SHALL have port tx_start  input  1  request to send din; valid only while tx_busy=0.
REQ-008 The block SHALL have port din  input  8  byte to send; bits [DBIT-1:0] used, upper bits ignored.
REQ-009 The block SHALL have port tx  output  1  serial line, registered, idle high.
REQ-010 The block SHALL have port tx_busy  output  1  high from the accept cycle until the frame completes.
REQ-011 The block SHALL have port tx_done_tick  output  1  one-clk pulse at the end of the stop phase.

Function
REQ-012 The FSM SHALL have states idle, start, data, parity and stop; the parity state is bypassed when PARITY=0.
REQ-013 In idle, tx_start=1 SHALL accept the request: latch din[DBIT-1:0] into the shift register, clear the tick counter s and the bit counter n, and enter start; tx SHALL go low on the following clk edge.
REQ-014 tx_start while tx_busy=1 SHALL be ignored, and the frame in progress SHALL be unaffected; din changes after accept SHALL NOT affect the frame.
REQ-015 The start state SHALL hold tx=0 for 16 s_tick periods: s counts on s_tick, and s==15 with s_tick clears s and enters data.
REQ-016 The data state SHALL drive the shift register LSB on tx for 16 s_tick periods per bit; at s==15 with s_tick, the register SHALL shift right, s SHALL clear and n SHALL increment.
REQ-017 At n==DBIT-1 with end-of-bit, data SHALL exit to parity when PARITY!=0, otherwise to stop.
REQ-018 The parity bit SHALL be the XOR of the latched data bits for PARITY=1 and its inverse for PARITY=2; it SHALL be held on tx for 16 s_tick periods.
REQ-019 The stop state SHALL hold tx=1 for SB_TICK s_tick periods; at s==SB_TICK-1 with s_tick, the block SHALL pulse tx_done_tick for exactly one clk and return to idle in the same edge.
REQ-020 The s counter SHALL be wide enough for SB_TICK-1; counters SHALL advance only on cycles with s_tick=1.
REQ-021 tx_busy SHALL be 0 only in idle; a tx_start in the cycle after tx_done_tick SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-022 Frame length SHALL be (1+DBIT+(PARITY!=0))*16+SB_TICK s_tick periods.
REQ-023 tx SHALL be glitch-free, driven from a flop, and change only on clk edges.

Reset
REQ-024 reset_n=0 at a clk edge SHALL force state=idle, s=0, n=0, shift register=0, tx=1, tx_busy=0 and tx_done_tick=0 at that edge.
REQ-025 Reset during any frame phase SHALL abort the frame, with tx high on the next edge and no tx_done_tick.
REQ-026 Reset SHALL take priority over a tx_start in the same cycle; that request SHALL be dropped.

Verification
REQ-027 Defaults, din=8'hA5, tx_start for 1 clk, s_tick every 4 clk -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; tx_done_tick is a single pulse 640 clk after accept.
REQ-028 PARITY=1, din=8'h07 -> parity bit 1; PARITY=2, din=8'h07 -> parity bit 0; frame is 11 bits.
REQ-029 tx_start with din=8'h3C pulsed mid-frame while sending 8'h55 -> 8'h55 frame unchanged, 8'h3C never sent.
REQ-030 tx_start with 8'h01 held high through tx_done_tick, then 8'h80 -> two contiguous frames; the start bit of the second follows the stop bit directly.
REQ-031 reset_n low for 1 clk during data bit 3 -> tx=1 and tx_busy=0 next clk, no tx_done_tick; a new tx_start then sends a full frame.
REQ-032 DBIT=7, SB_TICK=32, din=8'hFF -> 7 data ones, stop phase lasting 32 s_tick periods, din[7] ignored.
